quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Quadrature front-end sitting directly upstream of the team's 4-bit up/down counter.
- Synchronises and glitch-filters raw encoder channels A/B.
- Decodes Gray-code transitions into a one-cycle step pulse plus a direction level; the direction level uses the counter's convention (0 = up, 1 = down).
- Flags and counts illegal double transitions.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2).
- FILT_LEN, 4, consecutive cycles a synchronised input must differ from its filtered value before the change is accepted (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a_in  input  1  raw encoder channel A, asynchronous.
- b_in  input  1  raw encoder channel B, asynchronous.
- err_clr  input  1  synchronous clear of err_count.
- step  output  1  one-cycle pulse per legal quadrature transition.
- dir  output  1  direction of last legal step; 0 = forward/up, 1 = reverse/down.
- err  output  1  one-cycle pulse on an illegal transition.
- err_count  output  ERR_CNT_W  saturating count of err pulses.
- ab_filt  output  2  filtered state {A,B}.

Behaviour:
- Reset (reset=1 at a rising edge):
  - sync chains, filters, filter counters, prev state, startup counter, armed flag, step, dir, err, err_count and ab_filt all go to 0.
  - Reset mid-operation aborts everything identically.
- Synchroniser: each channel passes through SYNC_STAGES flops. No other logic touches raw inputs.
- Filter, per channel, with counter width clog2(FILT_LEN)+1:
  - sync == filt: cnt <= 0.
  - sync != filt and cnt < FILT_LEN-1: cnt <= cnt+1.
  - sync != filt and cnt == FILT_LEN-1: filt <= sync, cnt <= 0.
  - A pulse shorter than FILT_LEN synchronised cycles never reaches filt.
- Startup blanking:
  - After reset deasserts, a counter runs for SYNC_STAGES+FILT_LEN+1 edges.
  - At the last of these edges: prev <= ab_filt, armed <= 1.
  - step and err remain 0 until armed. This prevents spurious errors from nonzero idle inputs.
- Decode (armed, registered, compare ab_filt against prev each edge, prev <= ab_filt every edge):
  - Forward sequence 00->10->11->01->00: step <= 1, dir <= 0.
  - Reverse sequence 00->01->11->10->00: step <= 1, dir <= 1.
  - No change: step <= 0, dir holds.
  - Both bits changed (00<->11, 10<->01): err <= 1, step <= 0, dir holds.
- Latency: a_in toggles and is stable before edge k -> step high for exactly the cycle after edge k+SYNC_STAGES+FILT_LEN (k+6 at defaults).
- Back-to-back legal transitions separated by >= FILT_LEN cycles each produce their own step. No step is merged or dropped.
- err_count:
  - Increments on each err pulse; saturates at 2^ERR_CNT_W-1 with no wrap.
  - err_clr has priority: clears to 0.
  - err_clr and err in the same cycle -> count = 1.
- dir is a level: valid whenever step=1 and stable between steps. The downstream counter samples it together with step.

Test Plan:
- Reset with a_in=b_in=0, then drive a forward sequence {A,B}=10,11,01,00, each held 10 cycles -> 4 step pulses with dir=0, each 6 cycles after its input edge; err=0; ab_filt follows the sequence.
- From armed idle at 00, drive reverse sequence 01,11,10,00, 10 cycles each -> 4 step pulses with dir=1; feeding a downstream counter from 0 gives 15,14,13,12.
- Glitch: at ab_filt=00, pulse a_in high for 3 cycles (FILT_LEN=4) -> no step, ab_filt stays 00. Pulse a_in for 4 cycles -> ab_filt goes 10 then back to 00; one forward step, then one reverse step.
- Illegal jump: at 00, drive a_in and b_in high on the same edge -> ab_filt 11, one err pulse, no step, dir unchanged, err_count=1. Repeat 300 times with ERR_CNT_W=8 -> err_count saturates at 255. Assert err_clr coincident with an err -> err_count=1.
- Startup: hold a_in=b_in=1 through reset, release reset -> ab_filt reaches 11, armed sets at edge 7, no err, no step.
- Reset mid-operation: assert reset for 1 cycle during a forward sequence -> all outputs 0 next cycle; blanking restarts; no step within 7 edges after release.

Source files
------------

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature encoder front-end for the 4-bit up/down counter.
// Synchronises and glitch-filters raw A/B, blanks decode while the pipeline fills
// after reset, then turns Gray-code moves into a step pulse plus a direction level
// (0 = up, 1 = down) and counts illegal double transitions.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 err_clr,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           ab_filt
);

  localparam int                   CW         = $clog2(FILT_LEN) + 1;
  localparam logic [CW-1:0]        CNT_LAST   = CW'(FILT_LEN - 1);
  localparam int                   BLANK      = SYNC_STAGES + FILT_LEN + 1;
  localparam int                   BW         = $clog2(BLANK) + 1;
  localparam logic [BW-1:0]        BLANK_LAST = BW'(BLANK - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

  logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
  logic [1:0]             syncAb;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]          blank_q, blank_d;
  logic                   armed_q, armed_d;
  logic [1:0]             prev_q, prev_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   errCount_q, errCount_d;

  // Bit 1 carries channel A and bit 0 channel B throughout, matching ab_filt.
  assign syncAb = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

  // Plain shift-register synchronisers; nothing else looks at the raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA_q <= '0;
      syncB_q <= '0;
    end else begin
      syncA_q <= {syncA_q[SYNC_STAGES-2:0], a_in};
      syncB_q <= {syncB_q[SYNC_STAGES-2:0], b_in};
    end
  end

  // Per-channel filter: accept a new level only after FILT_LEN consecutive disagreeing cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (syncAb[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          filt_d[ch] = syncAb[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  // Startup blanking, Gray-code decode and the saturating error counter.
  always_comb begin
    blank_d    = blank_q;
    armed_d    = armed_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    errCount_d = errCount_q;
    if (!armed_q) begin
      if (blank_q == BLANK_LAST) begin
        armed_d = 1'b1;
        prev_d  = filt_q;
      end else begin
        blank_d = blank_q + BW'(1);
      end
    end else begin
      prev_d = filt_q;
      case ({prev_q, filt_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
          err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
    // The count moves on the same edge that raises err, so a clear sampled on
    // that edge still leaves this error counted.
    if (err_clr) begin
      errCount_d = err_d ? ERR_CNT_W'(1) : '0;
    end else if (err_d && (errCount_q != ERR_MAX)) begin
      errCount_d = errCount_q + ERR_CNT_W'(1);
    end
  end

  // State and registered outputs; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= '0;
      cnt_q      <= '0;
      blank_q    <= '0;
      armed_q    <= 1'b0;
      prev_q     <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      errCount_q <= '0;
    end else begin
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      errCount_q <= errCount_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign err_count = errCount_q;
  assign ab_filt   = filt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: table of held input levels with expected step/err/dir
// results, hand sequences for latency, glitches, saturation, startup and reset,
// then random input traffic. A behavioural model runs alongside the whole time.
module tb_quad_step_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  localparam int ERR_CNT_W   = 8;
  localparam int BLANK       = SYNC_STAGES + FILT_LEN + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 a_in = 1'b0;
  logic                 b_in = 1'b0;
  logic                 err_clr = 1'b0;
  logic                 step;
  logic                 dir;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           ab_filt;

  int checks = 0;
  int errors = 0;

  int         stepSeen = 0;
  int         errSeen = 0;
  logic [3:0] downCnt = 4'd0;
  logic       stepDirs[$];

  typedef struct {
    logic [1:0] ab;
    int         hold;
    logic       zeroCnt;
    int         expSteps;
    int         expErrs;
    logic       expDir;
    logic [1:0] expFilt;
    logic [3:0] expCnt;
  } vec_t;

  vec_t vecs[13];

  quad_step_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .err_count(err_count),
    .ab_filt  (ab_filt)
  );

  always #5 clk = ~clk;

  // Reference model: input history queue, run-length filter, Gray position arithmetic.
  logic [1:0] mHist[$];
  logic [1:0] mFilt = 2'b00;
  int         mRun[2] = '{0, 0};
  int         mEdges = 0;
  logic       mArmed = 1'b0;
  logic [1:0] mPrev = 2'b00;
  logic       mStep = 1'b0;
  logic       mDir = 1'b0;
  logic       mErr = 1'b0;
  int         mErrCnt = 0;

  function automatic int grayPos(input logic [1:0] code);
    case (code)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [1:0] synced;
    logic [1:0] oldFilt;
    int         delta;
    if (reset) begin
      mHist = {};
      for (int i = 0; i < SYNC_STAGES; i++) mHist.push_back(2'b00);
      mFilt   = 2'b00;
      mRun    = '{0, 0};
      mEdges  = 0;
      mArmed  = 1'b0;
      mPrev   = 2'b00;
      mStep   = 1'b0;
      mDir    = 1'b0;
      mErr    = 1'b0;
      mErrCnt = 0;
    end else begin
      if (mHist.size() != SYNC_STAGES) begin
        mHist = {};
        for (int i = 0; i < SYNC_STAGES; i++) mHist.push_back(2'b00);
      end
      synced  = mHist[SYNC_STAGES-1];
      oldFilt = mFilt;
      mHist.push_front({a_in, b_in});
      void'(mHist.pop_back());
      for (int ch = 0; ch < 2; ch++) begin
        if (synced[ch] != oldFilt[ch]) begin
          mRun[ch] = mRun[ch] + 1;
          if (mRun[ch] == FILT_LEN) begin
            mFilt[ch] = synced[ch];
            mRun[ch]  = 0;
          end
        end else begin
          mRun[ch] = 0;
        end
      end
      mStep = 1'b0;
      mErr  = 1'b0;
      if (mArmed) begin
        delta = (grayPos(oldFilt) - grayPos(mPrev) + 4) % 4;
        if (delta == 1) begin
          mStep = 1'b1;
          mDir  = 1'b0;
        end else if (delta == 3) begin
          mStep = 1'b1;
          mDir  = 1'b1;
        end else if (delta == 2) begin
          mErr = 1'b1;
        end
        mPrev = oldFilt;
      end else begin
        mEdges = mEdges + 1;
        if (mEdges == BLANK) begin
          mArmed = 1'b1;
          mPrev  = oldFilt;
        end
      end
      if (err_clr) mErrCnt = mErr ? 1 : 0;
      else if (mErr && mErrCnt < (1 << ERR_CNT_W) - 1) mErrCnt = mErrCnt + 1;
    end
  end

  task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkEq("model step", 32'(step), 32'(mStep));
    checkEq("model dir", 32'(dir), 32'(mDir));
    checkEq("model err", 32'(err), 32'(mErr));
    checkEq("model err_count", 32'(err_count), 32'(mErrCnt));
    checkEq("model ab_filt", 32'(ab_filt), 32'(mFilt));
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare on the falling edge.
  task automatic applyStimulus(input logic [1:0] ab, input logic clr, input logic rst);
    a_in    = ab[1];
    b_in    = ab[0];
    err_clr = clr;
    reset   = rst;
    @(negedge clk);
    checkOutput();
    if (step === 1'b1) begin
      stepSeen++;
      stepDirs.push_back(dir);
      downCnt = (dir === 1'b1) ? downCnt - 4'd1 : downCnt + 4'd1;
    end
    if (err === 1'b1) errSeen++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before the test completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    int   hold;
    logic sawNonZero;
    logic saw10;
    logic [1:0] ab;

    vecs[0]  = '{2'b10, 10, 1'b0, 1, 0, 1'b0, 2'b10, 4'd1};
    vecs[1]  = '{2'b11, 10, 1'b0, 1, 0, 1'b0, 2'b11, 4'd2};
    vecs[2]  = '{2'b01, 10, 1'b0, 1, 0, 1'b0, 2'b01, 4'd3};
    vecs[3]  = '{2'b00, 10, 1'b0, 1, 0, 1'b0, 2'b00, 4'd4};
    vecs[4]  = '{2'b01, 10, 1'b1, 1, 0, 1'b1, 2'b01, 4'd15};
    vecs[5]  = '{2'b11, 10, 1'b0, 1, 0, 1'b1, 2'b11, 4'd14};
    vecs[6]  = '{2'b10, 10, 1'b0, 1, 0, 1'b1, 2'b10, 4'd13};
    vecs[7]  = '{2'b00, 10, 1'b0, 1, 0, 1'b1, 2'b00, 4'd12};
    vecs[8]  = '{2'b11, 10, 1'b0, 0, 1, 1'b1, 2'b11, 4'd12};
    vecs[9]  = '{2'b00, 10, 1'b0, 0, 1, 1'b1, 2'b00, 4'd12};
    vecs[10] = '{2'b10, 10, 1'b0, 1, 0, 1'b0, 2'b10, 4'd13};
    vecs[11] = '{2'b01, 10, 1'b0, 0, 1, 1'b0, 2'b01, 4'd13};
    vecs[12] = '{2'b00, 10, 1'b0, 1, 0, 1'b0, 2'b00, 4'd14};

    // Reset state.
    @(negedge clk);
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkEq("reset step", 32'(step), 32'd0);
    checkEq("reset dir", 32'(dir), 32'd0);
    checkEq("reset err", 32'(err), 32'd0);
    checkEq("reset err_count", 32'(err_count), 32'd0);
    checkEq("reset ab_filt", 32'(ab_filt), 32'd0);
    for (int c = 0; c < 10; c++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Table of held levels: forward, reverse, illegal jumps.
    downCnt = 4'd0;
    for (int r = 0; r < 13; r++) begin
      if (vecs[r].zeroCnt) downCnt = 4'd0;
      stepSeen = 0;
      errSeen  = 0;
      for (int c = 0; c < vecs[r].hold; c++) applyStimulus(vecs[r].ab, 1'b0, 1'b0);
      checkEq($sformatf("row%0d steps", r), 32'(stepSeen), 32'(vecs[r].expSteps));
      checkEq($sformatf("row%0d errs", r), 32'(errSeen), 32'(vecs[r].expErrs));
      checkEq($sformatf("row%0d dir", r), 32'(dir), 32'(vecs[r].expDir));
      checkEq($sformatf("row%0d ab_filt", r), 32'(ab_filt), 32'(vecs[r].expFilt));
      checkEq($sformatf("row%0d counter", r), 32'(downCnt), 32'(vecs[r].expCnt));
    end
    checkEq("table err_count", 32'(err_count), 32'd3);

    // Latency: input applied before edge k, step visible after edge k+6.
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(2'b10, 1'b0, 1'b0);
      if (step === 1'b1 && lat < 0) lat = n - 1;
    end
    checkEq("step latency", 32'(lat), 32'(SYNC_STAGES + FILT_LEN));
    for (int c = 0; c < 10; c++) applyStimulus(2'b00, 1'b0, 1'b0);

    // Glitch of FILT_LEN-1 cycles never reaches the filtered state.
    stepSeen = 0;
    sawNonZero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b10, 1'b0, 1'b0);
      if (ab_filt !== 2'b00) sawNonZero = 1'b1;
    end
    for (int c = 0; c < 12; c++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      if (ab_filt !== 2'b00) sawNonZero = 1'b1;
    end
    checkEq("short glitch steps", 32'(stepSeen), 32'd0);
    checkEq("short glitch ab_filt moved", 32'(sawNonZero), 32'd0);

    // Pulse of exactly FILT_LEN cycles passes: one forward then one reverse step.
    stepSeen = 0;
    stepDirs = {};
    saw10 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b10, 1'b0, 1'b0);
      if (ab_filt === 2'b10) saw10 = 1'b1;
    end
    for (int c = 0; c < 14; c++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      if (ab_filt === 2'b10) saw10 = 1'b1;
    end
    checkEq("long glitch steps", 32'(stepSeen), 32'd2);
    checkEq("long glitch saw 10", 32'(saw10), 32'd1);
    checkEq("long glitch final ab_filt", 32'(ab_filt), 32'd0);
    if (stepDirs.size() == 2) begin
      checkEq("long glitch dir 1st", 32'(stepDirs[0]), 32'd0);
      checkEq("long glitch dir 2nd", 32'(stepDirs[1]), 32'd1);
    end

    // Saturation: 300 illegal jumps push err_count to its ceiling.
    errSeen = 0;
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 8; c++) applyStimulus((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0);
    end
    checkEq("saturation err pulses", 32'(errSeen), 32'd300);
    checkEq("saturation err_count", 32'(err_count), 32'd255);

    // err_clr sampled on the same edge that raises err leaves a count of 1.
    for (int n = 1; n <= 7; n++) applyStimulus(2'b11, (n == 7) ? 1'b1 : 1'b0, 1'b0);
    checkEq("clr+err err", 32'(err), 32'd1);
    checkEq("clr+err err_count", 32'(err_count), 32'd1);
    for (int c = 0; c < 3; c++) applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkEq("clr alone err_count", 32'(err_count), 32'd0);

    // Startup with both inputs high: no spurious err or step.
    applyStimulus(2'b11, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b0, 1'b1);
    stepSeen = 0;
    errSeen  = 0;
    for (int c = 0; c < 20; c++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkEq("startup steps", 32'(stepSeen), 32'd0);
    checkEq("startup errs", 32'(errSeen), 32'd0);
    checkEq("startup ab_filt", 32'(ab_filt), 32'd3);

    // Reset mid-operation with nonzero dir, err_count and ab_filt.
    for (int c = 0; c < 10; c++) applyStimulus(2'b00, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(2'b01, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b1);
    checkEq("midreset step", 32'(step), 32'd0);
    checkEq("midreset dir", 32'(dir), 32'd0);
    checkEq("midreset err", 32'(err), 32'd0);
    checkEq("midreset err_count", 32'(err_count), 32'd0);
    checkEq("midreset ab_filt", 32'(ab_filt), 32'd0);
    stepSeen = 0;
    errSeen  = 0;
    for (int c = 0; c < 15; c++) applyStimulus(2'b01, 1'b0, 1'b0);
    checkEq("after midreset steps", 32'(stepSeen), 32'd0);
    checkEq("after midreset errs", 32'(errSeen), 32'd0);
    checkEq("after midreset ab_filt", 32'(ab_filt), 32'd1);

    // Random traffic against the model, with occasional clears and resets.
    for (int n = 0; n < 800; n += hold) begin
      ab   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        applyStimulus(ab, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
